// File: rtl/fp_mavg_if.sv
// -----------------------------------------------------------------------------
// sfp : signed fixed-point sample stream
//
// Purpose
//    Carries one fixed-point sample value plus format tags that describe
//    the value's layout. Consumers read the tag widths at elaboration time
//    to confirm that both ends agree on the number format.
//
// Parameters
//    iw         integer bits, sign bit included
//    qw         fractional bits
//    is_signed  1 = two's complement samples, 0 = unsigned
//
// Signals
//    val           sample value, iw+qw bits
//    dummy_qw      format tag, width qw+1
//    dummy_wl      format tag, width iw+qw+1
//    dummy_signed  format tag, width 1 when signed, 2 when unsigned
//
// Modports
//    master  producer side, drives val
//    slave   consumer side, reads val
// -----------------------------------------------------------------------------
interface sfp #(
   parameter int iw        = 4,
   parameter int qw        = 4,
   parameter bit is_signed = 1'b1
);

   logic signed [iw+qw-1:0]      val;
   logic [qw:0]                  dummy_qw;
   logic [iw+qw:0]               dummy_wl;
   logic [(is_signed ? 0 : 1):0] dummy_signed;

   // The tags only carry width information; their values are meaningless.
   assign dummy_qw     = '0;
   assign dummy_wl     = '0;
   assign dummy_signed = '0;

   modport master (output val, input dummy_qw, input dummy_wl, input dummy_signed);
   modport slave  (input  val, input dummy_qw, input dummy_wl, input dummy_signed);

endinterface

// File: rtl/fp_mavg.sv
// -----------------------------------------------------------------------------
// fp_mavg : streaming fixed-point moving-average filter
//
// Purpose
//    Averages the last N = 2**log2n signed samples. Each accepted sample
//    updates a running sum (add the new sample, subtract the one leaving
//    the window) and produces the rounded, saturated mean one cycle later.
//
// Ports
//    clk        clock
//    rst        synchronous active-high reset
//    in_valid   din.val holds a new sample this cycle
//    clear      synchronous window flush (applied before a same-cycle sample)
//    din        sfp slave, input sample (in_iw.in_qw)
//    dout       sfp master, window mean (out_iw.out_qw), holds when idle
//    out_valid  dout.val updated this cycle
//    primed     window holds N samples since last reset/clear
//    ovf        sticky saturation flag (only with FP_MAVG_OVF_FLAG_EN)
//
// Configuration
//    FP_MAVG_OVF_FLAG_EN  when defined, adds the sticky ovf output port
// -----------------------------------------------------------------------------
module fp_mavg #(
   parameter int in_iw  = 4,
   parameter int in_qw  = 4,
   parameter int out_iw = 4,
   parameter int out_qw = 4,
   parameter int log2n  = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic clear,
   sfp.slave    din,
   sfp.master   dout,
   output logic out_valid,
   output logic primed
`ifdef FP_MAVG_OVF_FLAG_EN
   ,
   output logic ovf
`endif
);

   localparam int N   = 1 << log2n;
   localparam int W   = in_iw + in_qw;
   localparam int OW  = out_iw + out_qw;
   localparam int AW  = W + log2n;
   localparam int PW  = (log2n > 0) ? log2n : 1;
   localparam int FW  = log2n + 1;

   // Shift that turns the sum (in_qw+log2n fraction bits) into out_qw bits.
   localparam int SH  = in_qw + log2n - out_qw;
   localparam int RSH = (SH > 0) ? SH : 0;
   localparam int LSH = (SH < 0) ? -SH : 0;

   // Conversion width: room for the rounding add, any left shift, and the
   // saturation comparison against the output range.
   localparam int CW0 = AW + 2 + LSH;
   localparam int CW  = (CW0 > OW + 1) ? CW0 : OW + 1;

   localparam logic signed [CW-1:0] RND  =
      (RSH > 0) ? (CW'(1) << ((RSH > 0) ? RSH - 1 : 0)) : '0;
   localparam logic signed [CW-1:0] MAXV = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [CW-1:0] MINV = ~MAXV;

   // Elaboration-time format checks on both stream ends.
   if ($bits(din.dummy_qw) - 1 != in_qw || $bits(din.dummy_wl) - 1 != in_iw + in_qw) begin : g_din_fmt
      $fatal(1, "fp_mavg: din format does not match in_iw/in_qw");
   end
   if ($bits(dout.dummy_qw) - 1 != out_qw || $bits(dout.dummy_wl) - 1 != out_iw + out_qw) begin : g_dout_fmt
      $fatal(1, "fp_mavg: dout format does not match out_iw/out_qw");
   end
   if ($bits(din.dummy_signed) != 1 || $bits(dout.dummy_signed) != 1) begin : g_sign_fmt
      $fatal(1, "fp_mavg: din and dout must be signed");
   end
   if (log2n < 0 || log2n > 12) begin : g_log2n_range
      $fatal(1, "fp_mavg: log2n must be in 0..12");
   end

   typedef enum logic {FILL, STEADY} state_t;

   state_t                 state;
   state_t                 state_eff;
   state_t                 state_next;

   logic signed [AW-1:0]   acc;
   logic [PW-1:0]          wptr;
   logic [FW-1:0]          fill;
   logic signed [W-1:0]    hist [N];

   logic signed [AW-1:0]   acc_base;
   logic [PW-1:0]          wptr_eff;
   logic [PW-1:0]          wptr_next;
   logic [FW-1:0]          fill_eff;
   logic signed [W-1:0]    old;
   logic signed [AW-1:0]   acc_next;
   logic signed [CW-1:0]   ext;
   logic signed [CW-1:0]   scaled;
   logic                   saturate;
   logic [OW-1:0]          result;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // Next state. A clear behaves as if the window were already flushed, so
   // a same-cycle sample counts as the first sample of a fresh window.
   always_comb begin
      state_eff  = clear ? FILL : state;
      state_next = state_eff;
      if (in_valid && state_eff == FILL && fill_eff == FW'(N - 1)) begin
         state_next = STEADY;
      end
   end

   // FSM outputs.
   always_comb begin
      primed = (state == STEADY);
   end

   // Running-sum update and fixed-point conversion of the new mean.
   always_comb begin
      acc_base  = clear ? '0 : acc;
      wptr_eff  = clear ? '0 : wptr;
      fill_eff  = clear ? '0 : fill;
      wptr_next = (wptr_eff == PW'(N - 1)) ? '0 : wptr_eff + PW'(1);
      old       = (state_eff == STEADY) ? hist[wptr_eff] : '0;
      acc_next  = acc_base + AW'(din.val) - AW'(old);

      ext      = CW'(acc_next);
      scaled   = ((ext + RND) >>> RSH) <<< LSH;
      saturate = (scaled > MAXV) || (scaled < MINV);

      if (scaled > MAXV) begin
         result = MAXV[OW-1:0];
      end else if (scaled < MINV) begin
         result = MINV[OW-1:0];
      end else begin
         result = scaled[OW-1:0];
      end
   end

   // Datapath registers; dout.val only moves when a sample is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         wptr      <= '0;
         fill      <= '0;
         out_valid <= 1'b0;
         dout.val  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            acc      <= acc_next;
            wptr     <= wptr_next;
            fill     <= (state_eff == FILL) ? fill_eff + FW'(1) : fill_eff;
            dout.val <= result;
         end else begin
            acc  <= acc_base;
            wptr <= wptr_eff;
            fill <= fill_eff;
         end
      end
   end

   // History buffer is not reset; FILL never reads stale entries.
   always_ff @(posedge clk) begin
      if (!rst && in_valid) begin
         hist[wptr_eff] <= din.val;
      end
   end

`ifdef FP_MAVG_OVF_FLAG_EN
   // Sticky overflow; a saturating sample on a clear cycle re-arms it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (clear) begin
         ovf <= in_valid & saturate;
      end else if (in_valid && saturate) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_mavg.sv
// -----------------------------------------------------------------------------
// tb_fp_mavg : self-checking bench for fp_mavg
//
// Drives one input stream into two filters: dut_a with the default format
// and dut_b with a narrow 2.4 output that saturates easily. A queue-based
// window model computes the expected mean for both.
// -----------------------------------------------------------------------------
module tb_fp_mavg;

   localparam int N  = 4;
   localparam int SH = 2;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic clear;
   logic out_valid_a;
   logic primed_a;
   logic out_valid_b;
   logic primed_b;
`ifdef FP_MAVG_OVF_FLAG_EN
   logic ovf_a;
   logic ovf_b;
`endif

   sfp #(.iw(4), .qw(4)) din_if ();
   sfp #(.iw(4), .qw(4)) dout_a_if ();
   sfp #(.iw(2), .qw(4)) dout_b_if ();

   fp_mavg dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .clear     (clear),
      .din       (din_if),
      .dout      (dout_a_if),
      .out_valid (out_valid_a),
      .primed    (primed_a)
`ifdef FP_MAVG_OVF_FLAG_EN
      ,
      .ovf       (ovf_a)
`endif
   );

   fp_mavg #(.out_iw(2)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .clear     (clear),
      .din       (din_if),
      .dout      (dout_b_if),
      .out_valid (out_valid_b),
      .primed    (primed_b)
`ifdef FP_MAVG_OVF_FLAG_EN
      ,
      .ovf       (ovf_b)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int     window[$];
   longint exp_dout_a;
   longint exp_dout_b;
   logic   exp_valid;
   logic   exp_primed;
   logic   exp_ovf_a;
   logic   exp_ovf_b;

   // Mathematical floor division (SV '/' truncates toward zero).
   function automatic longint floorDiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   // Mean of the window sum in out_qw fraction bits, round half toward +inf.
   function automatic longint scaleMean(input longint sum);
      return floorDiv(sum + (longint'(1) << (SH - 1)), longint'(1) << SH);
   endfunction

   function automatic longint clampTo(input longint v, input int ow);
      longint hi;
      longint lo;
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -(longint'(1) << (ow - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("out_valid_a", {31'b0, out_valid_a}, {31'b0, exp_valid});
      checkOutput("dout_a", {24'b0, dout_a_if.val}, 32'(exp_dout_a) & 32'hFF);
      checkOutput("primed_a", {31'b0, primed_a}, {31'b0, exp_primed});
      checkOutput("out_valid_b", {31'b0, out_valid_b}, {31'b0, exp_valid});
      checkOutput("dout_b", {26'b0, dout_b_if.val}, 32'(exp_dout_b) & 32'h3F);
      checkOutput("primed_b", {31'b0, primed_b}, {31'b0, exp_primed});
`ifdef FP_MAVG_OVF_FLAG_EN
      checkOutput("ovf_a", {31'b0, ovf_a}, {31'b0, exp_ovf_a});
      checkOutput("ovf_b", {31'b0, ovf_b}, {31'b0, exp_ovf_b});
`endif
   endtask

   // One clock of stimulus; the model is updated from the same inputs.
   task automatic applyStimulus(input logic v, input logic c, input logic [7:0] d);
      longint sum;
      longint mean;
      in_valid   = v;
      clear      = c;
      din_if.val = d;
      if (c) begin
         window.delete();
         exp_ovf_a = 1'b0;
         exp_ovf_b = 1'b0;
      end
      exp_valid = v;
      if (v) begin
         window.push_back(int'($signed(d)));
         if (window.size() > N) void'(window.pop_front());
         sum = 0;
         foreach (window[i]) sum += window[i];
         mean       = scaleMean(sum);
         exp_dout_a = clampTo(mean, 8);
         exp_dout_b = clampTo(mean, 6);
         if (exp_dout_a != mean) exp_ovf_a = 1'b1;
         if (exp_dout_b != mean) exp_ovf_b = 1'b1;
      end
      exp_primed = (window.size() >= N);
      @(posedge clk);
      #1;
      checkAll();
   endtask

   task automatic doReset(input int cycles);
      rst        = 1'b1;
      in_valid   = 1'b0;
      clear      = 1'b0;
      din_if.val = '0;
      window.delete();
      exp_dout_a = 0;
      exp_dout_b = 0;
      exp_valid  = 1'b0;
      exp_primed = 1'b0;
      exp_ovf_a  = 1'b0;
      exp_ovf_b  = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         checkAll();
      end
      rst = 1'b0;
   endtask

   logic [7:0] step_in  [8] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
   logic [7:0] step_exp [8] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h08, 8'h00, 8'hF8, 8'hF0};
   logic [5:0] sat_exp  [4] = '{6'h1C, 6'h1F, 6'h1F, 6'h1F};

   initial begin
      logic v;
      logic c;
      logic [7:0] d;

      // Reset state and idle hold before the first sample.
      doReset(3);
      repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("reset_dout", {24'b0, dout_a_if.val}, 32'h00);

      // Step response across a full window and its wrap.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, step_in[i]);
         checkOutput("step_dout", {24'b0, dout_a_if.val}, {24'b0, step_exp[i]});
      end

      // Rounding of single-sample windows.
      applyStimulus(1'b0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h02);
      checkOutput("round_02", {24'b0, dout_a_if.val}, 32'h01);
      applyStimulus(1'b0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'hFE);
      checkOutput("round_tie", {24'b0, dout_a_if.val}, 32'h00);
      applyStimulus(1'b0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h01);
      checkOutput("round_01", {24'b0, dout_a_if.val}, 32'h00);

      // Saturation on the narrow-output filter.
      applyStimulus(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h70);
         checkOutput("sat_dout", {26'b0, dout_b_if.val}, {26'b0, sat_exp[i]});
      end
      applyStimulus(1'b0, 1'b1, 8'h00);

      // Clear colliding with a sample, then idle gaps.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h10);
      applyStimulus(1'b1, 1'b1, 8'h20);
      checkOutput("collide_dout", {24'b0, dout_a_if.val}, 32'h08);
      checkOutput("collide_primed", {31'b0, primed_a}, 32'h0);
      repeat (5) applyStimulus(1'b0, 1'b0, 8'h55);
      checkOutput("idle_hold", {24'b0, dout_a_if.val}, 32'h08);

      // Mid-operation reset leaves no stale history behind.
      applyStimulus(1'b1, 1'b1, 8'h10);
      applyStimulus(1'b1, 1'b0, 8'h10);
      doReset(1);
      applyStimulus(1'b1, 1'b0, 8'h10);
      checkOutput("post_reset", {24'b0, dout_a_if.val}, 32'h04);

      // Randomized traffic with occasional clears, collisions and resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            doReset(1);
         end else begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            d = 8'($urandom());
            applyStimulus(v, c, d);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_mavg.md
Name: fp_mavg

Overview:
Streaming fixed-point moving-average filter over a power-of-two window, N = 2**log2n samples.
- Consumes signed samples on an `sfp` input interface and produces the rounded, saturated window mean on an `sfp` output interface.
- Sits directly downstream of any `sfp` producer, typically a decimator or ADC front end, and feeds the next `sfp` consumer.

Parameters:
in_iw, 4, integer bits of din, sign bit included
in_qw, 4, fractional bits of din
out_iw, 4, integer bits of dout, sign bit included
out_qw, 4, fractional bits of dout
log2n, 2, log2 of window length; legal range 0..12

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  din.val holds a new sample this cycle
clear  input  1  synchronous window flush
din  sfp.in  in_iw+in_qw  input sample
dout  sfp.out  out_iw+out_qw  window mean
out_valid  output  1  dout updated this cycle
primed  output  1  window holds N samples since last reset/clear

Behaviour:
- Interface and reset: one clock, clk. Reset rst is synchronous and active-high.
- Elaboration checks:
  - Fatal if $bits(din.dummy_qw)-1 != in_qw or $bits(din.dummy_wl)-1 != in_iw+in_qw.
  - The same checks apply to dout against out_qw and out_iw+out_qw.
  - Fatal if din or dout is unsigned ($bits(dummy_signed) != 1).
- Reset: acc=0, wptr=0, fill=0, state=FILL, dout.val=0, out_valid=0, primed=0.
  - History buffer contents are not reset.
  - rst asserted mid-operation discards the window; the next cycle shows reset values.
- Storage:
  - Circular history buffer of N entries, each in_iw+in_qw bits.
  - wptr is log2n bits and wraps N-1 -> 0.
  - acc is signed, in_iw+in_qw+log2n bits, and can never overflow.
- Accepted sample: x = din.val on a cycle with in_valid=1.
  - old = buf[wptr] in STEADY, and 0 in FILL.
  - acc <= acc + x - old; buf[wptr] <= x; wptr <= wptr+1.
- States:
  - FILL: fill counts accepted samples. On the Nth sample go to STEADY; primed rises in the same cycle as that sample's out_valid.
  - STEADY: stays until rst or clear.
  - log2n=0 enters STEADY on the first sample.
- Output conversion: m = acc_next, the updated sum, with in_qw+log2n fractional bits. s = in_qw+log2n-out_qw.
  - s>0: round half-up, m = (m + 2**(s-1)) >>> s. Ties go toward +inf.
  - s<=0: m = m <<< -s.
  - Saturate to [-2**(out_iw+out_qw-1), 2**(out_iw+out_qw-1)-1].
- Latency and holding:
  - Registered. out_valid=1 and the new dout.val appear in the cycle after in_valid.
  - No accepted sample -> out_valid=0 and dout.val holds.
- clear: acc, wptr and fill go to 0, state to FILL, primed to 0; dout.val holds.
  - clear with in_valid in the same cycle: the flush applies first, and x becomes the first sample of the new window.
  - The output in that case is x/N, with out_valid=1 next cycle.
- No backpressure: every in_valid cycle is consumed.

Optional Feature:
FP_MAVG_OVF_FLAG_EN
- Defined:
  - Adds output port ovf (1 bit), a sticky flag, reset value 0.
  - ovf is set in the cycle out_valid reports a saturated result.
  - Cleared by rst or clear. clear with a saturating in_valid in the same cycle leaves ovf=1.
- Undefined: the port and its logic are absent; saturation is silent.

Test Plan:
- Reset check (defaults): hold rst 3 cycles, then release. -> dout.val=0x00, out_valid=0, primed=0 until the first in_valid.
- Step response and wrap (defaults): feed 0x10 (1.0) four times back to back, then 0xF0 (-1.0) four times.
  - Outputs: 0x04, 0x08, 0x0C, 0x10, then 0x08, 0x00, 0xF8, 0xF0.
  - primed rises with the 4th output.
- Rounding (defaults), after clear:
  - Single sample 0x02 -> dout 0x01.
  - Clear, then single sample 0xFE -> dout 0x00 (tie rounds toward +inf).
  - Clear, then 0x01 -> dout 0x00.
- Saturation and ovf (out_iw=2, out_qw=4, macro defined): feed 0x70 (7.0) four times.
  - Outputs: 0x1C (1.75), then 0x1F, 0x1F, 0x1F (saturated).
  - ovf=1 from the 2nd output; clear drops ovf to 0.
- Clear collision and gaps (defaults): fill with 1.0, then assert clear with in_valid and din=0x20.
  - Next output 0x08, primed=0.
  - Idle 5 cycles: out_valid=0, dout.val stays 0x08.
- Mid-operation reset (defaults): pulse rst after 2 samples of 0x10, then feed 0x10 once. -> Output 0x04, confirming no stale history.
